cmac_result_packer: RTL and testbench
=====================================

Name: cmac_result_packer

Overview:
- Downstream stage of the convolution MAC (cmac). Captures each finished fp16 convolution result, indicated by a rising edge on the MAC's conv_valid level.
- Packs result pairs into 32-bit words, buffers them in a small FIFO and streams them to the host write-back pipe over a valid/ready handshake.
- Tracks the per-layer result count, signals layer completion and flags overflow.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words; power of two, at least 2
- CNT_W, 32, width of result counters and total_num

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- layer_start  in  1  one-cycle pulse; arms the block for a new layer, clears counters, FIFO and error flag
- total_num  in  CNT_W  number of fp16 results expected this layer; sampled on layer_start
- conv_valid  in  1  cmac completion level; the block acts only on its rising edge
- result  in  16  cmac fp16 result (ReLU already applied); valid while conv_valid is high
- wr_data  out  32  packed word; [15:0] = earlier result, [31:16] = later result
- wr_valid  out  1  wr_data holds a FIFO word
- wr_ready  in  1  sink accepts the word when wr_valid && wr_ready at posedge
- fifo_count  out  $clog2(DEPTH)+1  words currently buffered
- results_seen  out  CNT_W  results captured this layer
- layer_done  out  1  level; high in DONE state
- err_overflow  out  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset: all state and counters cleared; state IDLE; outputs wr_data=0, wr_valid=0, fifo_count=0, results_seen=0, layer_done=0, err_overflow=0. Reset mid-operation discards buffered data.
- Edge detect: register conv_d <= conv_valid every cycle.
  - Capture event cap = conv_valid && !conv_d, sampled at posedge; result is sampled on the same edge.
  - A conv_valid level held for many cycles counts once.
- State IDLE: captures ignored. layer_start -> COLLECT, latch total_num, clear results_seen, half flag, FIFO and err_overflow. If total_num == 0 -> DONE instead.
- State COLLECT, on cap:
  - results_seen++.
  - If half flag clear: store result in low_half, set half flag.
  - Else: push {result, low_half}, clear half flag.
  - When the capture makes results_seen == total: if the half flag was clear (odd total), push {16'h0000, result} and do not set the flag. Then -> FLUSH.
- Captures after results_seen == total are ignored.
- State FLUSH: wait until fifo_count == 0 -> DONE.
- State DONE: layer_done=1; wait for layer_start, which re-arms exactly as from IDLE.
- layer_start in COLLECT or FLUSH: abort; same re-arm action, clearing the FIFO in the same cycle; layer_done stays 0.
- layer_start has priority over a coincident cap; that capture is discarded.
- Push/pop rules:
  - Pop on wr_valid && wr_ready.
  - A push when fifo_count == DEPTH and no pop is dropped and sets err_overflow.
  - Push while full with a simultaneous pop is accepted; count is unchanged.
  - Simultaneous push and pop at any level leaves count unchanged.
- Latency: a word pushed at edge N gives wr_valid=1 from the cycle after edge N (first-word-fall-through; wr_data valid whenever wr_valid).
- wr_valid = (fifo_count != 0).
- Read and write pointers wrap modulo DEPTH.
- No backpressure to cmac exists; the sink is responsible for keeping up.

Decomposition:
- Shared package fusion_pkg:
  - packer state encoding: IDLE=2'd0, COLLECT=2'd1, FLUSH=2'd2, DONE=2'd3
  - FP16_W=16, WORD_W=32
  - FP16_ZERO=16'h0000
- Sub-module sync_fifo (WIDTH, DEPTH): first-word-fall-through, synchronous reset, clear input, count output.
- Packing FSM and counters live in cmac_result_packer.

Test Plan:
- Even layer: total_num=4, conv_valid rises with results 3C00,4000,4200,4400, wr_ready=1 -> words 40003C00 then 44004200; then layer_done=1, results_seen=4.
- Odd layer with held level: total_num=3, conv_valid held high 5 cycles per result with 3C00,3800,3400 -> words 38003C00, 00003400; results_seen=3 (no double count).
- Backpressure/overflow: DEPTH=2, wr_ready=0, total_num=6 with 6 captures -> fifo_count=2, err_overflow=1; release wr_ready -> first two words out; state stays FLUSH until empty, then DONE.
- Full with simultaneous pop: full FIFO, push and pop in the same cycle -> err_overflow stays 0, fifo_count stays DEPTH.
- Abort: layer_start after 1 capture in COLLECT, coincident with a cap -> fifo_count=0, results_seen=0, coincident capture discarded; new layer of total_num=2 packs correctly.
- Zero/reset: layer_start with total_num=0 -> layer_done=1 next cycle. rst asserted mid-COLLECT -> all outputs 0 on the following cycle.

Source files
------------

// File: rtl/fusion_pkg.sv
// rtl/fusion_pkg.sv - shared types and constants for the cmac result packer
//
// Purpose: packer state encoding and the fp16/word widths used by the
// cmac result path.
package fusion_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } packer_state_t;

  localparam int FP16_W = 16;
  localparam int WORD_W = 32;

  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with clear
//
// Purpose: small word buffer between the packer and the write-back pipe.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clear        drops all buffered words (priority over push/pop)
//   push         write push_data; accepted if not full or popping this cycle
//   push_data    word to store
//   pop          consume the head word (ignored when empty)
//   pop_data     head word, zero when empty
//   count        words currently held
//   full         count == DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmac_result_packer.sv
// rtl/cmac_result_packer.sv - packs cmac fp16 results into 32-bit write-back words
//
// Purpose: captures one fp16 result per rising edge of conv_valid, pairs
// results into words (earlier result in [15:0]), buffers them and streams
// them out over a valid/ready handshake; tracks the per-layer count.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   layer_start    pulse; re-arms for a new layer of total_num results
//   total_num      results expected this layer (sampled on layer_start)
//   conv_valid     cmac completion level; acted on at its rising edge
//   result         fp16 result valid while conv_valid is high
//   wr_data        packed head word
//   wr_valid       wr_data holds a buffered word
//   wr_ready       sink accepts the word
//   fifo_count     words buffered
//   results_seen   results captured this layer
//   layer_done     high once the layer is fully drained
//   err_overflow   sticky; a word was dropped on a full FIFO
module cmac_result_packer
  import fusion_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer_start,
  input  logic [CNT_W-1:0]          total_num,
  input  logic                      conv_valid,
  input  logic [FP16_W-1:0]         result,
  output logic [WORD_W-1:0]         wr_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          results_seen,
  output logic                      layer_done,
  output logic                      err_overflow
);

  packer_state_t     state;
  logic              conv_d;
  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  seen_q;
  logic              half_q;
  logic [FP16_W-1:0] low_half;
  logic              done_q;
  logic              err_q;

  logic              cap;
  logic              take;
  logic              last;
  logic              push;
  logic [WORD_W-1:0] push_data;
  logic              pop;
  logic              full;
  logic              drop;

  assign cap = conv_valid && !conv_d;

  // layer_start wins over a coincident capture; captures past the
  // expected total are ignored.
  assign take = (state == COLLECT) && cap && !layer_start && (seen_q != total_q);
  assign last = ((seen_q + CNT_W'(1)) == total_q);

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (take) begin
      if (half_q) begin
        push      = 1'b1;
        push_data = {result, low_half};
      end else if (last) begin
        // Odd total: the final result goes out alone, upper half zeroed.
        push      = 1'b1;
        push_data = {FP16_ZERO, result};
      end
    end
  end

  assign pop  = wr_valid && wr_ready;
  assign drop = push && full && !pop;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (layer_start),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (wr_data),
    .count     (fifo_count),
    .full      (full)
  );

  assign wr_valid     = (fifo_count != '0);
  assign results_seen = seen_q;
  assign layer_done   = done_q;
  assign err_overflow = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      conv_d   <= 1'b0;
      total_q  <= '0;
      seen_q   <= '0;
      half_q   <= 1'b0;
      low_half <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      conv_d <= conv_valid;
      if (layer_start) begin
        total_q <= total_num;
        seen_q  <= '0;
        half_q  <= 1'b0;
        err_q   <= 1'b0;
        if (total_num == '0) begin
          state  <= DONE;
          done_q <= 1'b1;
        end else begin
          state  <= COLLECT;
          done_q <= 1'b0;
        end
      end else begin
        if (drop) begin
          err_q <= 1'b1;
        end
        case (state)
          COLLECT: begin
            if (take) begin
              seen_q <= seen_q + CNT_W'(1);
              if (half_q) begin
                half_q <= 1'b0;
              end else if (!last) begin
                low_half <= result;
                half_q   <= 1'b1;
              end
              if (last) begin
                state <= FLUSH;
              end
            end
          end
          FLUSH: begin
            if (fifo_count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmac_result_packer.sv
// tb/tb_cmac_result_packer.sv - self-checking bench for cmac_result_packer
module tb_cmac_result_packer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 32;

  logic              clk;
  logic              rst;
  logic              layer_start;
  logic [CNT_W-1:0]  total_num;
  logic              conv_valid;
  logic [15:0]       result;
  logic [31:0]       wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        fifo_count;
  logic [CNT_W-1:0]  results_seen;
  logic              layer_done;
  logic              err_overflow;

  int n_cmp;
  int n_err;

  cmac_result_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .layer_start  (layer_start),
    .total_num    (total_num),
    .conv_valid   (conv_valid),
    .result       (result),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .fifo_count   (fifo_count),
    .results_seen (results_seen),
    .layer_done   (layer_done),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of words, a list of pending results, a phase.
  logic [31:0] m_q[$];
  logic [15:0] m_pend[$];
  int          m_phase;   // 0 idle, 1 collecting, 2 draining, 3 done
  int          m_total;
  int          m_seen;
  bit          m_ovf;
  bit          m_conv_d;

  logic [31:0] got[$];

  task automatic model_edge();
    bit cap;
    bit pop;
    int size_before;
    logic [31:0] w;
    bit have_w;
    cap = conv_valid && !m_conv_d;
    size_before = m_q.size();
    pop = (size_before != 0) && wr_ready;
    m_conv_d = conv_valid;
    if (rst) begin
      m_q.delete(); m_pend.delete();
      m_phase = 0; m_total = 0; m_seen = 0; m_ovf = 0; m_conv_d = 0;
      return;
    end
    if (layer_start) begin
      m_q.delete(); m_pend.delete();
      m_total = int'(total_num); m_seen = 0; m_ovf = 0;
      m_phase = (total_num == 0) ? 3 : 1;
      return;
    end
    if (pop) void'(m_q.pop_front());
    have_w = 0;
    w = '0;
    if (m_phase == 1 && cap && m_seen < m_total) begin
      m_seen++;
      m_pend.push_back(result);
      if (m_pend.size() == 2) begin
        w = {m_pend[1], m_pend[0]}; have_w = 1; m_pend.delete();
      end else if (m_seen == m_total) begin
        w = {16'h0000, m_pend[0]}; have_w = 1; m_pend.delete();
      end
      if (m_seen == m_total) m_phase = 2;
    end else if (m_phase == 2 && size_before == 0) begin
      m_phase = 3;
    end
    if (have_w) begin
      if (m_q.size() >= DEPTH) m_ovf = 1;
      else m_q.push_back(w);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ed;
    ed = (m_q.size() != 0) ? m_q[0] : 32'h0;
    check("wr_valid",     32'(wr_valid),     32'(m_q.size() != 0));
    check("wr_data",      wr_data,           ed);
    check("fifo_count",   32'(fifo_count),   32'(m_q.size()));
    check("results_seen", results_seen,      32'(m_seen));
    check("layer_done",   32'(layer_done),   32'(m_phase == 3));
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
  endtask

  task automatic step();
    if (wr_valid && wr_ready) got.push_back(wr_data);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_layer(input int tn);
    layer_start = 1'b1;
    total_num = CNT_W'(tn);
    step();
    layer_start = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] v, input int hi, input int lo);
    conv_valid = 1'b1;
    result = v;
    steps(hi);
    conv_valid = 1'b0;
    result = 16'hxxxx;
    steps(lo);
  endtask

  task automatic run_until_done(input string tag, input int max);
    int i;
    i = 0;
    while (!layer_done && i < max) begin
      step();
      i++;
    end
    check(tag, 32'(layer_done), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_q.delete(); m_pend.delete();
    m_phase = 0; m_total = 0; m_seen = 0; m_ovf = 0; m_conv_d = 0;
    rst = 1'b1; layer_start = 1'b0; total_num = '0;
    conv_valid = 1'b0; result = '0; wr_ready = 1'b1;

    // Reset state
    steps(2);
    rst = 1'b0;
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_done", 32'(layer_done), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);

    // Even layer
    got.delete();
    start_layer(4);
    pulse(16'h3C00, 1, 1);
    pulse(16'h4000, 1, 1);
    pulse(16'h4200, 1, 1);
    pulse(16'h4400, 1, 1);
    run_until_done("even_done", 20);
    check("even_seen", results_seen, 32'd4);
    check("even_nwords", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("even_w0", got[0], 32'h40003C00);
      check("even_w1", got[1], 32'h44004200);
    end

    // Odd layer, level held for several cycles per result
    got.delete();
    start_layer(3);
    pulse(16'h3C00, 5, 2);
    pulse(16'h3800, 5, 2);
    pulse(16'h3400, 5, 2);
    run_until_done("odd_done", 20);
    check("odd_seen", results_seen, 32'd3);
    check("odd_nwords", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("odd_w0", got[0], 32'h38003C00);
      check("odd_w1", got[1], 32'h00003400);
    end

    // Backpressure and overflow
    got.delete();
    wr_ready = 1'b0;
    start_layer(6);
    for (int k = 0; k < 6; k++) pulse(16'h1000 + 16'(k), 1, 1);
    check("ovf_count", 32'(fifo_count), 32'd2);
    check("ovf_flag", 32'(err_overflow), 32'd1);
    steps(3);
    check("ovf_hold_notdone", 32'(layer_done), 32'd0);
    wr_ready = 1'b1;
    run_until_done("ovf_done", 20);
    check("ovf_nwords", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("ovf_w0", got[0], 32'h10011000);
      check("ovf_w1", got[1], 32'h10031002);
    end

    // Full FIFO with push and pop in the same cycle
    wr_ready = 1'b0;
    start_layer(6);
    for (int k = 0; k < 5; k++) pulse(16'h2000 + 16'(k), 1, 1);
    check("fp_full", 32'(fifo_count), 32'd2);
    wr_ready = 1'b1;
    conv_valid = 1'b1; result = 16'h2005;
    step();
    conv_valid = 1'b0;
    check("fp_count", 32'(fifo_count), 32'd2);
    check("fp_noovf", 32'(err_overflow), 32'd0);
    run_until_done("fp_done", 20);

    // Abort mid-collect with a coincident capture
    got.delete();
    start_layer(4);
    pulse(16'h5555, 1, 1);
    conv_valid = 1'b1; result = 16'h6666;
    layer_start = 1'b1; total_num = 2;
    step();
    layer_start = 1'b0; conv_valid = 1'b0;
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_seen", results_seen, 32'd0);
    check("abort_done", 32'(layer_done), 32'd0);
    step();
    pulse(16'h7777, 1, 1);
    pulse(16'h8888, 1, 1);
    run_until_done("abort_new_done", 20);
    check("abort_nwords", 32'(got.size()), 32'd1);
    if (got.size() == 1) check("abort_w0", got[0], 32'h88887777);

    // Zero-length layer
    start_layer(0);
    check("zero_done", 32'(layer_done), 32'd1);

    // Reset mid-collect
    start_layer(5);
    pulse(16'h1111, 1, 1);
    pulse(16'h2222, 1, 0);
    rst = 1'b1; conv_valid = 1'b0;
    step();
    rst = 1'b0;
    check("rstmid_valid", 32'(wr_valid), 32'd0);
    check("rstmid_data", wr_data, 32'd0);
    check("rstmid_seen", results_seen, 32'd0);
    check("rstmid_count", 32'(fifo_count), 32'd0);
    check("rstmid_done", 32'(layer_done), 32'd0);
    check("rstmid_err", 32'(err_overflow), 32'd0);

    // Randomized layers checked cycle-by-cycle against the model
    for (int l = 0; l < 60; l++) begin
      start_layer($urandom_range(0, 9));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 2) == 0) conv_valid = ~conv_valid;
        result      = 16'($urandom);
        wr_ready    = ($urandom_range(0, 3) != 0);
        layer_start = ($urandom_range(0, 60) == 0);
        total_num   = CNT_W'($urandom_range(0, 5));
        rst         = ($urandom_range(0, 150) == 0);
        step();
      end
      layer_start = 1'b0; rst = 1'b0; wr_ready = 1'b1; conv_valid = 1'b0;
      steps(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
